// File: rtl/alarm_trigger_ctrl_pkg.sv
// Shared definitions for the intrusion-alarm controller: state encoding and
// trigger-count helpers used by the controller, the overlay and the status LEDs.
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    ARMING    = 2'd1,
    ARMED     = 2'd2,
    TRIGGERED = 2'd3
  } alarm_state_e;

  localparam logic [7:0] TRIG_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == TRIG_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/alarm_trigger_ctrl_if.sv
// Sensor/button/frame inputs and display/status outputs of the alarm controller.
interface alarm_trigger_ctrl_if;

  logic       iSensor;
  logic       iClear_N;
  logic       iEnable;
  logic       iFrame_Start;
  logic       oVideo_On;
  logic [1:0] oState;
  logic [7:0] oTrig_Count;

  modport master (
    output iSensor, iClear_N, iEnable, iFrame_Start,
    input  oVideo_On, oState, oTrig_Count
  );

  modport slave (
    input  iSensor, iClear_N, iEnable, iFrame_Start,
    output oVideo_On, oState, oTrig_Count
  );

endinterface

// File: rtl/alarm_trigger_ctrl_sync_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; the filtered
// output only follows the synced input after DEBOUNCE_CYC unbroken cycles.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter logic        RESET_VAL    = 1'b0
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic raw_in,
  output logic db_out
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            meta_r;
  logic            sync_r;
  logic            db_r;
  logic [DB_W-1:0] cnt_r;

  // Synchronise, then count consecutive cycles of disagreement; any agreement restarts the count
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      db_r   <= RESET_VAL;
      cnt_r  <= {DB_W{1'b0}};
    end else begin
      meta_r <= raw_in;
      sync_r <= meta_r;
      if (sync_r != db_r) begin
        if (cnt_r == DB_LAST) begin
          db_r  <= sync_r;
          cnt_r <= {DB_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + DB_W'(1);
        end
      end else begin
        cnt_r <= {DB_W{1'b0}};
      end
    end
  end

  assign db_out = db_r;

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// Intrusion-alarm sequencer: conditions the raw inputs, runs the
// arm/exit-delay/trigger/hold FSM and updates the overlay flag on frame boundaries.
module alarm_trigger_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 250000,
  parameter int unsigned ARM_DELAY_CYC = 125000000,
  parameter int unsigned HOLD_CYC      = 250000000,
  parameter int unsigned CNT_W         = 28
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  alarm_trigger_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  alarm_state_e     state_r;
  logic [CNT_W-1:0] timer_r;
  logic [7:0]       trig_cnt_r;
  logic             video_r;
  logic             en_meta_r;
  logic             en_sync_r;
  logic             clr_prev_r;
  logic             sensor_db_s;
  logic             clr_db_s;
  logic             clr_pulse_s;
  logic             hold_done_s;

  sync_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RESET_VAL    (1'b0)
  ) u_sensor_db (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .raw_in (bus.iSensor),
    .db_out (sensor_db_s)
  );

  sync_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RESET_VAL    (1'b1)
  ) u_clear_db (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .raw_in (bus.iClear_N),
    .db_out (clr_db_s)
  );

  // Enable switch is only synchronised; clear history feeds the press-edge detector
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      en_meta_r  <= 1'b0;
      en_sync_r  <= 1'b0;
      clr_prev_r <= 1'b1;
    end else begin
      en_meta_r  <= bus.iEnable;
      en_sync_r  <= en_meta_r;
      clr_prev_r <= clr_db_s;
    end
  end

  assign clr_pulse_s = clr_prev_r & ~clr_db_s;
  assign hold_done_s = (timer_r == HOLD_LAST);

  // Alarm sequencer with shared state timer, trigger counter and frame-aligned display flag
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r    <= DISARMED;
      timer_r    <= {CNT_W{1'b0}};
      trig_cnt_r <= 8'd0;
      video_r    <= 1'b0;
    end else begin
      if (bus.iFrame_Start) begin
        video_r <= (state_r == TRIGGERED);
      end
      case (state_r)
        DISARMED: begin
          timer_r <= {CNT_W{1'b0}};
          if (en_sync_r) begin
            state_r <= ARMING;
          end
        end
        ARMING: begin
          if (!en_sync_r) begin
            state_r <= DISARMED;
            timer_r <= {CNT_W{1'b0}};
          end else if (timer_r == ARM_LAST) begin
            state_r <= ARMED;
            timer_r <= {CNT_W{1'b0}};
          end else begin
            timer_r <= timer_r + CNT_W'(1);
          end
        end
        ARMED: begin
          timer_r <= {CNT_W{1'b0}};
          if (!en_sync_r) begin
            state_r <= DISARMED;
          end else if (sensor_db_s) begin
            state_r    <= TRIGGERED;
            trig_cnt_r <= sat_inc8(trig_cnt_r);
          end
        end
        TRIGGERED: begin
          // Latched: only an accepted clear leaves, and a press before hold_done is dropped
          if (clr_pulse_s && hold_done_s) begin
            state_r <= en_sync_r ? ARMED : DISARMED;
            timer_r <= {CNT_W{1'b0}};
          end else if (!hold_done_s) begin
            timer_r <= timer_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= DISARMED;
          timer_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.oVideo_On   = video_r;
  assign bus.oState      = state_r;
  assign bus.oTrig_Count = trig_cnt_r;

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// Self-checking bench for alarm_trigger_ctrl: directed phases plus random input
// activity, compared cycle by cycle against a behavioural model of the alarm rules.
module tb_alarm_trigger_ctrl;

  localparam int DEB   = 4;
  localparam int ARM_D = 8;
  localparam int HOLD  = 16;
  localparam int FRAME = 20;

  logic iCLK;
  logic iRST_N;
  alarm_trigger_ctrl_if ifc ();

  alarm_trigger_ctrl #(
    .DEBOUNCE_CYC  (DEB),
    .ARM_DELAY_CYC (ARM_D),
    .HOLD_CYC      (HOLD),
    .CNT_W         (8)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (ifc)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // behavioural model: delays expressed as histories and ages since state entry
  int m_state;
  int m_enter;
  int m_cnt;
  int m_edge;
  bit m_video;
  bit s_dly[2];
  bit c_dly[2];
  bit e_dly[2];
  bit m_s_db;
  bit m_c_db;
  bit m_c_db_old;
  int s_run;
  int c_run;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_enter = 0; m_cnt = 0; m_edge = 0; m_video = 1'b0;
    s_dly[0] = 1'b0; s_dly[1] = 1'b0;
    c_dly[0] = 1'b1; c_dly[1] = 1'b1;
    e_dly[0] = 1'b0; e_dly[1] = 1'b0;
    m_s_db = 1'b0; m_c_db = 1'b1; m_c_db_old = 1'b1;
    s_run = 0; c_run = 0;
  endtask

  task automatic go_state(input int nxt);
    m_state = nxt;
    m_enter = m_edge;
  endtask

  task automatic db_step(input bit synced, inout bit db, inout int run);
    if (synced != db) begin
      run++;
      if (run == DEB) begin
        db  = synced;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_step();
    bit en;
    bit pulse;
    int age;
    en    = e_dly[1];
    pulse = m_c_db_old && !m_c_db;
    age   = m_edge - m_enter;
    if (ifc.iFrame_Start) m_video = (m_state == 3);
    case (m_state)
      0: if (en) go_state(1);
      1: begin
        if (!en) go_state(0);
        else if (age == ARM_D) go_state(2);
      end
      2: begin
        if (!en) go_state(0);
        else if (m_s_db) begin
          go_state(3);
          if (m_cnt < 255) m_cnt++;
        end
      end
      default: if (pulse && age >= HOLD) go_state(en ? 2 : 0);
    endcase
    m_c_db_old = m_c_db;
    db_step(s_dly[1], m_s_db, s_run);
    db_step(c_dly[1], m_c_db, c_run);
    s_dly[1] = s_dly[0]; s_dly[0] = ifc.iSensor;
    c_dly[1] = c_dly[0]; c_dly[0] = ifc.iClear_N;
    e_dly[1] = e_dly[0]; e_dly[0] = ifc.iEnable;
    m_edge++;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge iCLK);
      model_step();
      @(negedge iCLK);
      check_eq("state", 32'(ifc.oState), 32'(m_state));
      check_eq("video", 32'(ifc.oVideo_On), 32'(m_video));
      check_eq("count", 32'(ifc.oTrig_Count), 32'(m_cnt));
      cyc++;
      ifc.iFrame_Start = ((cyc % FRAME) == 0) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    ifc.iSensor = 1'b0; ifc.iClear_N = 1'b1; ifc.iEnable = 1'b0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    m_reset();
    check_eq("rst_state", 32'(ifc.oState), 32'd0);
    check_eq("rst_video", 32'(ifc.oVideo_On), 32'd0);
    check_eq("rst_count", 32'(ifc.oTrig_Count), 32'd0);
    iRST_N = 1'b1;
  endtask

  task automatic press_clear(input int low_cyc, input int high_cyc);
    ifc.iClear_N = 1'b0;
    tick(low_cyc);
    ifc.iClear_N = 1'b1;
    tick(high_cyc);
  endtask

  initial begin
    int hs, hc, he;
    iRST_N = 1'b0;
    ifc.iFrame_Start = 1'b0;
    do_reset();
    tick(5);

    // arm: ARMING after sync, ARMED eight cycles later
    ifc.iEnable = 1'b1;
    tick(3);
    check_eq("arming", 32'(ifc.oState), 32'd1);
    tick(8);
    check_eq("armed", 32'(ifc.oState), 32'd2);

    // short sensor blip is filtered out
    ifc.iSensor = 1'b1;
    tick(3);
    ifc.iSensor = 1'b0;
    tick(10);
    check_eq("blip_cnt", 32'(ifc.oTrig_Count), 32'd0);

    // held sensor triggers after DEB+3 cycles
    ifc.iSensor = 1'b1;
    tick(6);
    check_eq("pre_trig", 32'(ifc.oState), 32'd2);
    tick(1);
    check_eq("trig", 32'(ifc.oState), 32'd3);
    check_eq("trig_cnt", 32'(ifc.oTrig_Count), 32'd1);
    ifc.iSensor = 1'b0;

    // early clear is discarded, later press re-arms
    press_clear(6, 2);
    check_eq("early_clr", 32'(ifc.oState), 32'd3);
    tick(10);
    press_clear(8, 8);
    check_eq("clr_armed", 32'(ifc.oState), 32'd2);
    tick(25);
    check_eq("video_off", 32'(ifc.oVideo_On), 32'd0);

    // enable dropped during ARMING
    ifc.iEnable = 1'b0;
    tick(4);
    ifc.iEnable = 1'b1;
    tick(6);
    ifc.iEnable = 1'b0;
    tick(4);
    check_eq("arm_abort", 32'(ifc.oState), 32'd0);

    // enable dropped while TRIGGERED: latched, then clear disarms
    ifc.iEnable = 1'b1;
    tick(12);
    ifc.iSensor = 1'b1;
    tick(8);
    ifc.iSensor = 1'b0;
    ifc.iEnable = 1'b0;
    tick(20);
    check_eq("trig_latched", 32'(ifc.oState), 32'd3);
    press_clear(8, 8);
    check_eq("clr_disarm", 32'(ifc.oState), 32'd0);

    // counter saturation with sensor held through repeated clears
    ifc.iEnable = 1'b1;
    tick(12);
    ifc.iSensor = 1'b1;
    tick(8);
    for (int i = 0; i < 300; i++) press_clear(8, 10);
    check_eq("sat_cnt", 32'(ifc.oTrig_Count), 32'd255);
    ifc.iSensor = 1'b0;

    // random activity on all inputs
    do_reset();
    hs = 0; hc = 0; he = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hs == 0) begin ifc.iSensor  = ($urandom_range(0, 1) == 1); hs = $urandom_range(1, 12); end
      if (hc == 0) begin ifc.iClear_N = ($urandom_range(0, 2) != 0); hc = $urandom_range(1, 12); end
      if (he == 0) begin ifc.iEnable  = ($urandom_range(0, 3) != 0); he = $urandom_range(1, 80); end
      hs--; hc--; he--;
      tick(1);
    end

    // asynchronous reset while the alarm is displayed
    do_reset();
    ifc.iEnable = 1'b1;
    tick(12);
    ifc.iSensor = 1'b1;
    tick(30);
    check_eq("pre_rst_video", 32'(ifc.oVideo_On), 32'd1);
    #2;
    iRST_N = 1'b0;
    #1;
    check_eq("async_state", 32'(ifc.oState), 32'd0);
    check_eq("async_video", 32'(ifc.oVideo_On), 32'd0);
    check_eq("async_count", 32'(ifc.oTrig_Count), 32'd0);
    do_reset();
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
